seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of N common-anode seven-segment digits. It takes a packed vector of 4-bit hex nibbles plus per-digit decimal-point and enable masks, and scans one digit per slot. Each slot starts with an anti-ghosting guard interval. The block adds tear-free frame-synchronous updates, leading-zero suppression and 8-level PWM brightness. It sits between the application's numeric registers and the board's anode/cathode pins.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 151 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high {a,b,c,d,e,f,g} glyphs for hex 0..F.
package seg7_pkg;

  // Entry n is the glyph for nibble n; entry 15 is listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph decoder, active-high segments.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb pattern = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous updates,
// leading-zero blanking and 8-level PWM brightness.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned SLOT_CYCLES  = 12500,
  parameter int unsigned GUARD_CYCLES = 250
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [2:0]              brightness,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int unsigned CW     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned ACTIVE = SLOT_CYCLES - GUARD_CYCLES;

  logic [CW-1:0]         slot_cnt;
  logic [IW-1:0]         idx;
  logic                  slot_last;
  logic                  boundary;

  logic [4*N_DIGITS-1:0] pend_value;
  logic [N_DIGITS-1:0]   pend_dp;
  logic [N_DIGITS-1:0]   pend_en;
  logic                  pend_flag;

  logic [4*N_DIGITS-1:0] sh_value;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_en;
  logic                  sh_lz;
  logic [2:0]            sh_bright;

  logic [N_DIGITS-1:0]   suppress;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_pat;
  logic [31:0]           on_len;
  logic [31:0]           slot_ext;
  logic                  lit;
  logic [N_DIGITS-1:0]   an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  assign slot_last = (slot_cnt == CW'(SLOT_CYCLES - 1));
  assign boundary  = slot_last && (idx == IW'(N_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      idx      <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // A load landing on the boundary bypasses the pending stage so it still
  // makes the very next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_flag  <= 1'b0;
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      sh_lz      <= 1'b0;
      sh_bright  <= '0;
    end else if (boundary) begin
      sh_lz     <= lz_en;
      sh_bright <= brightness;
      pend_flag <= 1'b0;
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp_in;
        sh_en    <= digit_en;
      end else if (pend_flag) begin
        sh_value <= pend_value;
        sh_dp    <= pend_dp;
        sh_en    <= pend_en;
      end
    end else if (load) begin
      pend_value <= value;
      pend_dp    <= dp_in;
      pend_en    <= digit_en;
      pend_flag  <= 1'b1;
    end
  end

  // Walk from the most significant digit; blanking stops at the first nonzero
  // nibble regardless of that digit's enable. Digit 0 is never visited.
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int unsigned k = 0; k + 1 < N_DIGITS; k++) begin
      zero_run = zero_run & (sh_value[4*(N_DIGITS-1-k) +: 4] == 4'h0);
      suppress[N_DIGITS-1-k] = sh_lz & zero_run;
    end
  end

  assign cur_nib = sh_value[4*idx +: 4];

  seg7_hex_decode u_decode (
    .nibble  (cur_nib),
    .pattern (cur_pat)
  );

  always_comb begin
    on_len   = (ACTIVE * (32'(sh_bright) + 32'd1)) >> 3;
    slot_ext = 32'(slot_cnt);
    lit      = sh_en[idx] && !suppress[idx] &&
               (slot_ext >= GUARD_CYCLES) && (slot_ext < GUARD_CYCLES + on_len);
    an_next  = '1;
    seg_next = '1;
    dp_next  = 1'b1;
    if (lit) begin
      an_next[idx] = 1'b0;
      seg_next     = ~cur_pat;
      dp_next      = ~sh_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, table-driven bench for seg7_scan_driver at 4 digits, 16-cycle slots, 2-cycle guard.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SC    = 16;
  localparam int GC    = 2;
  localparam int FRAME = ND * SC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [2:0]  brightness = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0]      value;
    logic [3:0]       dpv;
    logic [3:0]       en;
    logic             lz;
    logic [2:0]       br;
    logic [3:0][3:0]  on_exp;
    logic [3:0][6:0]  seg_exp;
    logic [3:0]       dp_exp;
  } vec_t;

  vec_t vecs[7];

  int         obs_on[4];
  int         obs_first[4];
  logic [6:0] obs_seg[4];
  logic       obs_dp[4];
  int         obs_bad;
  bit         obs_fd_bad;
  int         obs_first_k;
  logic [3:0] obs_first_an;
  int         wait_lit;

  seg7_scan_driver #(
    .N_DIGITS     (ND),
    .SLOT_CYCLES  (SC),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .lz_en      (lz_en),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    wait_lit = 0;
    do begin
      tick();
      n++;
      if (an !== 4'hF) wait_lit++;
    end while (frame_done !== 1'b1 && n < 200);
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic scan_frame(input int act_k, input bit do_load, input logic [15:0] v,
                            input logic [3:0] d, input logic [3:0] e, input logic [2:0] br);
    int lows;
    int dig;
    int pos;
    obs_bad     = 0;
    obs_fd_bad  = 1'b0;
    obs_first_k = -1;
    obs_first_an = 4'hF;
    for (int j = 0; j < 4; j++) begin
      obs_on[j] = 0; obs_first[j] = -1; obs_seg[j] = 7'h7F; obs_dp[j] = 1'b1;
    end
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      pos  = k - 1;
      lows = 0;
      dig  = -1;
      for (int j = 0; j < 4; j++)
        if (an[j] === 1'b0) begin lows++; dig = j; end
      if ($isunknown(an)) obs_bad++;
      else if (lows == 0) begin
        if (seg !== 7'h7F || dp !== 1'b1) obs_bad++;
      end else if (lows > 1 || dig != pos / SC) obs_bad++;
      else begin
        if (obs_first_k < 0) begin obs_first_k = k; obs_first_an = an; end
        if (obs_on[dig] > 0 && (seg !== obs_seg[dig] || dp !== obs_dp[dig])) obs_bad++;
        if (obs_on[dig] == 0) obs_first[dig] = pos % SC;
        obs_on[dig]++;
        obs_seg[dig] = seg;
        obs_dp[dig]  = dp;
      end
      if ((k < FRAME) == (frame_done === 1'b1)) obs_fd_bad = 1'b1;
      load = 1'b0;
      if (k == act_k) begin
        brightness = br;
        if (do_load) begin
          value = v; dp_in = d; digit_en = e; load = 1'b1;
        end
      end
    end
  endtask

  task automatic check_frame(input vec_t x, input string tag);
    scan_frame(-1, 1'b0, '0, '0, '0, brightness);
    check({tag, "_bad_cycles"}, obs_bad, 0);
    check({tag, "_frame_done"}, {31'd0, obs_fd_bad}, 0);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s_on%0d", tag, j), obs_on[j], x.on_exp[j]);
      if (x.on_exp[j] != 0) begin
        check($sformatf("%s_guard%0d", tag, j), obs_first[j], GC);
        check($sformatf("%s_seg%0d", tag, j), obs_seg[j], x.seg_exp[j]);
        check($sformatf("%s_dp%0d", tag, j), obs_dp[j], x.dp_exp[j]);
      end
    end
  endtask

  task automatic apply_vec(input vec_t x);
    lz_en = x.lz; brightness = x.br;
    value = x.value; dp_in = x.dpv; digit_en = x.en;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, an, 4'hF);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp"}, dp, 1);
    check({tag, "_fd"}, frame_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vb, vt, vbd, voff;
    int n;

    vecs[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, 3'd7, {4'd14, 4'd14, 4'd14, 4'd14},
                {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'hF};
    vecs[1] = '{16'h0042, 4'hF, 4'hF, 1'b1, 3'd7, {4'd0, 4'd0, 4'd14, 4'd14},
                {7'h7F, 7'h7F, 7'h4C, 7'h12}, 4'b1100};
    vecs[2] = '{16'h0000, 4'h1, 4'hF, 1'b1, 3'd3, {4'd0, 4'd0, 4'd0, 4'd7},
                {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1110};
    vecs[3] = '{16'h1234, 4'b0100, 4'b0101, 1'b0, 3'd0, {4'd0, 4'd1, 4'd0, 4'd1},
                {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1011};
    vecs[4] = '{16'h0A0F, 4'h0, 4'b1011, 1'b1, 3'd7, {4'd0, 4'd0, 4'd14, 4'd14},
                {7'h7F, 7'h08, 7'h01, 7'h38}, 4'hF};
    vecs[5] = '{16'h5000, 4'b1000, 4'b0111, 1'b1, 3'd5, {4'd0, 4'd10, 4'd10, 4'd10},
                {7'h7F, 7'h01, 7'h01, 7'h01}, 4'hF};
    vecs[6] = '{16'h0000, 4'b1010, 4'hF, 1'b0, 3'd7, {4'd14, 4'd14, 4'd14, 4'd14},
                {7'h01, 7'h01, 7'h01, 7'h01}, 4'b0101};
    vb   = '{16'h0000, 4'b1010, 4'hF, 1'b0, 3'd0, {4'd1, 4'd1, 4'd1, 4'd1},
             {7'h01, 7'h01, 7'h01, 7'h01}, 4'b0101};
    vt   = '{16'hABCD, 4'h0, 4'hF, 1'b0, 3'd7, {4'd14, 4'd14, 4'd14, 4'd14},
             {7'h08, 7'h60, 7'h31, 7'h42}, 4'hF};
    vbd  = '{16'h1234, 4'h0, 4'h5, 1'b0, 3'd7, {4'd0, 4'd14, 4'd0, 4'd14},
             {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'hF};
    voff = '0;

    // Reset held for three cycles.
    reset = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Release reset with a load in the first cycle; it lands at the first boundary.
    reset = 1'b0;
    apply_vec(vecs[0]);
    wait_fd(n);
    check("first_frame_len", n, FRAME - 1);
    check("first_frame_dark", wait_lit, 0);
    check_frame(vecs[0], "v0");
    check("first_low_tick", obs_first_k, GC + 1);
    check("first_low_an", obs_first_an, 4'hE);

    for (int i = 1; i < 7; i++) begin
      apply_vec(vecs[i]);
      wait_fd(n);
      check_frame(vecs[i], $sformatf("v%0d", i));
    end

    // Brightness drop mid-frame: current frame keeps full duty.
    scan_frame(20, 1'b0, '0, '0, '0, 3'd0);
    for (int j = 0; j < 4; j++) check($sformatf("br_mid_on%0d", j), obs_on[j], 14);
    check_frame(vb, "br0");

    // Restore full brightness for the following frames.
    scan_frame(5, 1'b0, '0, '0, '0, 3'd7);

    // Tear-free: load during digit 1's slot, old glyphs persist this frame.
    scan_frame(20, 1'b1, 16'hABCD, 4'h0, 4'hF, 3'd7);
    for (int j = 0; j < 4; j++) check($sformatf("tear_old_seg%0d", j), obs_seg[j], 7'h01);
    check_frame(vt, "tear");

    // Load exactly on the boundary cycle goes straight into the next frame.
    scan_frame(63, 1'b1, 16'h1234, 4'h0, 4'h5, 3'd7);
    check("bnd_old_seg0", obs_seg[0], 7'h42);
    check("bnd_old_seg3", obs_seg[3], 7'h08);
    check_frame(vbd, "bnd");

    // Mid-slot reset with a pending load outstanding.
    repeat (10) tick();
    value = 16'hFFFF; digit_en = 4'hF; dp_in = 4'hF; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    check("pre_reset_an", an, 4'hE);
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    repeat (2) tick();
    reset = 1'b0;
    wait_fd(n);
    check("post_reset_frame_len", n, FRAME);
    check("post_reset_dark", wait_lit, 0);
    check_frame(voff, "rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
